// File: rtl/traffic_light_ctrl.sv
// Round-robin multi-approach traffic-light controller with pedestrian walk
// phases and emergency pre-emption; every output comes straight from a flop.
module traffic_light_ctrl #(
   parameter int NUM_DIR    = 2,
   parameter int DIR_W      = 3,
   parameter int CNT_W      = 8,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_DIR-1:0]     ped_req,
   input  logic                   emerg_req,
   input  logic [DIR_W-1:0]       emerg_dir,
   output logic [2*NUM_DIR-1:0]   color,
   output logic [NUM_DIR-1:0]     walk,
   output logic [2:0]             action,
   output logic [DIR_W-1:0]       active_dir,
   output logic [CNT_W-1:0]       remaining
);

   typedef enum logic [2:0] {
      PH_ALLRED = 3'd0,
      PH_GREEN  = 3'd1,
      PH_YELLOW = 3'd2,
      PH_WALK   = 3'd3,
      PH_EMERG  = 3'd4
   } phase_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
   localparam logic [DIR_W-1:0] DIR_ZERO  = {DIR_W{1'b0}};
   localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);
   localparam logic [DIR_W:0]   NUM_DIR_X = (DIR_W + 1)'(NUM_DIR);

   function automatic logic [NUM_DIR-1:0] dir_onehot(input logic [DIR_W-1:0] d);
      logic [NUM_DIR-1:0] oh;
      for (int i = 0; i < NUM_DIR; i++) begin
         oh[i] = (d == DIR_W'(i));
      end
      return oh;
   endfunction

   phase_t               phase_r, phase_s;
   logic [DIR_W-1:0]     dir_r, dir_s, next_dir_s, emerg_dir_s;
   logic [CNT_W-1:0]     rem_r, rem_s;
   logic [NUM_DIR-1:0]   ped_pend_r, ped_pend_s, ped_clr_s;
   logic [NUM_DIR-1:0]   walk_r, walk_s, lane_s;
   logic [2*NUM_DIR-1:0] color_r, color_s;
   logic [1:0]           lamp_s;
   logic                 emerg_pend_r, emerg_pend_s, done_s;

   // Approach arithmetic: end-of-phase flag, rotation successor, sanitised emergency approach
   always_comb begin
      done_s = (rem_r == CNT_ZERO);
      if (dir_r == LAST_DIR) begin
         next_dir_s = DIR_ZERO;
      end else begin
         next_dir_s = dir_r + DIR_W'(1);
      end
      if ({1'b0, emerg_dir} < NUM_DIR_X) begin
         emerg_dir_s = emerg_dir;
      end else begin
         emerg_dir_s = DIR_ZERO;
      end
   end

   // Phase sequencing: next phase, served approach, timer and request latches
   always_comb begin
      phase_s   = phase_r;
      dir_s     = dir_r;
      rem_s     = rem_r - CNT_W'(1);
      ped_clr_s = {NUM_DIR{1'b0}};
      case (phase_r)
         PH_ALLRED: begin
            if (!done_s) begin
               phase_s = PH_ALLRED;
            end else if (emerg_pend_r || emerg_req) begin
               phase_s = PH_EMERG;
               dir_s   = emerg_dir_s;
               rem_s   = CNT_ZERO;
            end else if (|(ped_pend_r & dir_onehot(next_dir_s))) begin
               phase_s   = PH_WALK;
               dir_s     = next_dir_s;
               rem_s     = WALK_LD;
               ped_clr_s = dir_onehot(next_dir_s);
            end else begin
               phase_s = PH_GREEN;
               dir_s   = next_dir_s;
               rem_s   = GREEN_LD;
            end
         end
         PH_WALK: begin
            if (emerg_req) begin
               phase_s = PH_ALLRED;
               rem_s   = ALLRED_LD;
            end else if (done_s) begin
               phase_s = PH_GREEN;
               rem_s   = GREEN_LD;
            end else begin
               phase_s = PH_WALK;
            end
         end
         PH_GREEN: begin
            // Pre-emption for the approach already green keeps the lamp lit into EMERG
            if (emerg_req && (emerg_dir_s == dir_r)) begin
               phase_s = PH_EMERG;
               rem_s   = CNT_ZERO;
            end else if (emerg_req || done_s) begin
               phase_s = PH_YELLOW;
               rem_s   = YELLOW_LD;
            end else begin
               phase_s = PH_GREEN;
            end
         end
         PH_YELLOW: begin
            if (done_s) begin
               phase_s = PH_ALLRED;
               rem_s   = ALLRED_LD;
            end else begin
               phase_s = PH_YELLOW;
            end
         end
         PH_EMERG: begin
            if (emerg_req) begin
               phase_s = PH_EMERG;
               rem_s   = CNT_ZERO;
            end else begin
               phase_s = PH_YELLOW;
               rem_s   = YELLOW_LD;
            end
         end
         default: begin
            phase_s = PH_ALLRED;
            dir_s   = LAST_DIR;
            rem_s   = ALLRED_LD;
         end
      endcase

      // A request arriving in the same cycle as the clear survives
      ped_pend_s = (ped_pend_r & ~ped_clr_s) | ped_req;
      if (phase_s == PH_EMERG) begin
         emerg_pend_s = 1'b0;
      end else begin
         emerg_pend_s = emerg_pend_r | emerg_req;
      end
   end

   // Lamp and walk decode from the upcoming phase so the outputs can be registered
   always_comb begin
      lane_s = dir_onehot(dir_s);
      case (phase_s)
         PH_GREEN:  lamp_s = 2'b01;
         PH_EMERG:  lamp_s = 2'b01;
         PH_YELLOW: lamp_s = 2'b10;
         default:   lamp_s = 2'b00;
      endcase
      for (int i = 0; i < NUM_DIR; i++) begin
         color_s[2*i +: 2] = lane_s[i] ? lamp_s : 2'b00;
      end
      walk_s = (phase_s == PH_WALK) ? lane_s : {NUM_DIR{1'b0}};
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_r      <= PH_ALLRED;
         dir_r        <= LAST_DIR;
         rem_r        <= ALLRED_LD;
         ped_pend_r   <= {NUM_DIR{1'b0}};
         emerg_pend_r <= 1'b0;
         color_r      <= {(2*NUM_DIR){1'b0}};
         walk_r       <= {NUM_DIR{1'b0}};
      end else begin
         phase_r      <= phase_s;
         dir_r        <= dir_s;
         rem_r        <= rem_s;
         ped_pend_r   <= ped_pend_s;
         emerg_pend_r <= emerg_pend_s;
         color_r      <= color_s;
         walk_r       <= walk_s;
      end
   end

   assign action     = phase_r;
   assign active_dir = dir_r;
   assign remaining  = rem_r;
   assign color      = color_r;
   assign walk       = walk_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random
// stimulus compared every cycle against a phase/countdown reference model.
module tb_traffic_light_ctrl;

   localparam int NUM_DIR = 2;
   localparam int DIR_W   = 3;
   localparam int CNT_W   = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_DIR-1:0]   ped_req;
   logic                 emerg_req;
   logic [DIR_W-1:0]     emerg_dir;
   logic [2*NUM_DIR-1:0] color;
   logic [NUM_DIR-1:0]   walk;
   logic [2:0]           action;
   logic [DIR_W-1:0]     active_dir;
   logic [CNT_W-1:0]     remaining;

   traffic_light_ctrl #(
      .NUM_DIR(NUM_DIR), .DIR_W(DIR_W), .CNT_W(CNT_W),
      .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .WALK_CYC(3)
   ) dut (
      .clk(clk), .reset(reset), .ped_req(ped_req), .emerg_req(emerg_req),
      .emerg_dir(emerg_dir), .color(color), .walk(walk), .action(action),
      .active_dir(active_dir), .remaining(remaining)
   );

   always #5 clk = ~clk;

   // Spec action codes
   localparam int A = 0, G = 1, Y = 2, W = 3, E = 4;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: current phase code, served approach, cycles left in phase
   int m_ph, m_dir, m_left;
   bit [NUM_DIR-1:0] m_ped;
   bit m_em;

   int exp_seq [15] = '{1, 1, 1, 1, 2, 2, 0, 1, 1, 1, 1, 2, 2, 0, 1};

   function automatic int dur(input int ph);
      case (ph)
         G:       return 4;
         Y:       return 2;
         W:       return 3;
         default: return 1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input logic [1:0] p, input bit er, input logic [2:0] ed_raw);
      int ed, nd, np, ndir, clr;
      if (r) begin
         m_ph = A; m_dir = NUM_DIR - 1; m_left = dur(A); m_ped = '0; m_em = 1'b0;
         return;
      end
      ed   = (int'(ed_raw) < NUM_DIR) ? int'(ed_raw) : 0;
      np   = m_ph;
      ndir = m_dir;
      clr  = -1;
      case (m_ph)
         A: if (m_left == 1) begin
               if (m_em || er) begin
                  np = E; ndir = ed;
               end else begin
                  nd = (m_dir + 1) % NUM_DIR;
                  ndir = nd;
                  if (m_ped[nd]) begin np = W; clr = nd; end
                  else np = G;
               end
            end
         W: if (er) np = A; else if (m_left == 1) np = G;
         G: if (er) np = (ed == m_dir) ? E : Y; else if (m_left == 1) np = Y;
         Y: if (m_left == 1) np = A;
         default: if (!er) np = Y;
      endcase
      if (np != m_ph) m_left = dur(np);
      else if (m_ph != E) m_left = m_left - 1;
      else m_left = 1;
      if (clr >= 0) m_ped[clr] = 1'b0;
      m_ped = m_ped | p;
      m_em  = (np == E) ? 1'b0 : (m_em | er);
      m_ph  = np;
      m_dir = ndir;
   endtask

   task automatic compare_all();
      int exp_color, exp_walk, nonred;
      exp_color = 0;
      if (m_ph == G || m_ph == E) exp_color = 1 << (2 * m_dir);
      else if (m_ph == Y) exp_color = 2 << (2 * m_dir);
      exp_walk = (m_ph == W) ? (1 << m_dir) : 0;
      check("action", 32'(action), 32'(m_ph));
      check("active_dir", 32'(active_dir), 32'(m_dir));
      check("remaining", 32'(remaining), 32'(m_left - 1));
      check("color", 32'(color), 32'(exp_color));
      check("walk", 32'(walk), 32'(exp_walk));
      nonred = 0;
      for (int d = 0; d < NUM_DIR; d++) if (color[2*d +: 2] != 2'b00) nonred++;
      check("one_lane", 32'(nonred <= 1), 32'd1);
      check("walk_all_red", 32'((walk == '0) || (color == '0)), 32'd1);
   endtask

   task automatic tick(input bit r, input logic [1:0] p, input bit er, input logic [2:0] ed);
      reset = r; ped_req = p; emerg_req = er; emerg_dir = ed;
      @(posedge clk);
      #1;
      model_step(r, p, er, ed);
      compare_all();
   endtask

   task automatic run_until(input int ph, input int dir);
      int n;
      n = 0;
      while (!(m_ph == ph && m_dir == dir) && n < 60) begin
         tick(1'b0, 2'b00, 1'b0, 3'd0);
         n++;
      end
      check("run_until_bound", 32'(m_ph == ph && m_dir == dir), 32'd1);
   endtask

   initial begin
      int prev_act;
      bit e_on;
      logic [2:0] e_dir;

      // 1: free-running rotation from reset
      tick(1'b1, 2'b00, 1'b0, 3'd0);
      check("rst_action", 32'(action), 32'd0);
      check("rst_color", 32'(color), 32'd0);
      for (int i = 0; i < 15; i++) begin
         tick(1'b0, 2'b00, 1'b0, 3'd0);
         check("seq1", 32'(action), 32'(exp_seq[i]));
         if (i == 0) check("seq1_color_d0", 32'(color), 32'b0001);
         if (i == 7) check("seq1_color_d1", 32'(color), 32'b0100);
      end

      // 2: single pedestrian pulse for approach 1
      run_until(G, 0);
      tick(1'b0, 2'b10, 1'b0, 3'd0);
      run_until(W, 1);
      check("walk_d1", 32'(walk), 32'b10);
      check("walk_d1_red", 32'(color), 32'b0000);
      for (int i = 0; i < 20; i++) tick(1'b0, 2'b00, 1'b0, 3'd0);

      // 3: reset mid-GREEN d1 with a request pending
      run_until(G, 1);
      tick(1'b0, 2'b01, 1'b0, 3'd0);
      tick(1'b1, 2'b00, 1'b0, 3'd0);
      check("mid_rst_action", 32'(action), 32'd0);
      check("mid_rst_color", 32'(color), 32'd0);
      check("mid_rst_walk", 32'(walk), 32'd0);
      check("mid_rst_rem", 32'(remaining), 32'd0);
      tick(1'b0, 2'b00, 1'b0, 3'd0);
      check("post_rst_green", 32'(action), 32'd1);

      // 4: emergency for approach 1 while d0 is green
      run_until(G, 0);
      tick(1'b0, 2'b00, 1'b1, 3'd1);
      check("em_yellow", 32'(action), 32'd2);
      for (int i = 0; i < 3; i++) tick(1'b0, 2'b00, 1'b1, 3'd1);
      check("em_enter", 32'(action), 32'd4);
      check("em_color", 32'(color), 32'b0100);
      for (int i = 0; i < 5; i++) tick(1'b0, 2'b00, 1'b1, 3'd1);
      for (int i = 0; i < 4; i++) tick(1'b0, 2'b00, 1'b0, 3'd0);
      check("em_resume", 32'(action), 32'd1);
      check("em_resume_dir", 32'(active_dir), 32'd0);

      // 5: emergency for the approach already green; emerg_dir change ignored
      run_until(G, 0);
      tick(1'b0, 2'b00, 1'b1, 3'd0);
      check("em_same_action", 32'(action), 32'd4);
      check("em_same_color", 32'(color), 32'b0001);
      for (int i = 0; i < 4; i++) tick(1'b0, 2'b00, 1'b1, 3'd1);
      check("em_dir_held", 32'(active_dir), 32'd0);
      for (int i = 0; i < 6; i++) tick(1'b0, 2'b00, 1'b0, 3'd0);

      // 6: pedestrian request on approach 0 held high
      run_until(Y, 0);
      prev_act = int'(action);
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, 2'b01, 1'b0, 3'd0);
         if (action == 3'd1 && active_dir == 3'd0 && prev_act != 1)
            check("walk_before_green0", 32'(prev_act), 32'd3);
         prev_act = int'(action);
      end

      // Random traffic with out-of-range emergency approaches and stray resets
      e_on = 1'b0;
      e_dir = 3'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) e_on = !e_on;
         if ($urandom_range(0, 15) == 0) e_dir = 3'($urandom_range(0, 7));
         tick(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
              e_on, e_dir);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
